// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter slice.
//   - ALUC opcode constants (the arbiter only ever looks at ALUC_ILLEGAL)
//   - FSM state encoding
//   - default operand/result width
package alu_arb_pkg;

  localparam int DATA_WDTH_DEF = 32;

  // ADD is x000 on the ALU; 0000 is the canonical encoding.
  localparam logic [3:0] ALUC_ADD     = 4'b0000;
  localparam logic [3:0] ALUC_SUB     = 4'b0100;
  localparam logic [3:0] ALUC_XOR     = 4'b0010;
  localparam logic [3:0] ALUC_AND     = 4'b0001;
  localparam logic [3:0] ALUC_OR      = 4'b0101;
  localparam logic [3:0] ALUC_LUI     = 4'b0110;
  localparam logic [3:0] ALUC_SLL     = 4'b0011;
  localparam logic [3:0] ALUC_SRL     = 4'b0111;
  localparam logic [3:0] ALUC_SRA     = 4'b1111;
  localparam logic [3:0] ALUC_ILLEGAL = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_rr_arb.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : highest-priority index this round
//   grant : one-hot winner (all zero when no request)
//   idx   : encoded winner index
//   any   : at least one request present
// The pointer register is owned by the caller.
module rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int IW = $clog2(NUM_REQ);

  // Walk from ptr upward with manual wrap so NUM_REQ need not be a power of 2.
  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU among NUM_REQ
// requesters. One transaction in flight: IDLE (accept) -> EXEC (ALU works on
// the registered operands, result captured) -> RESP (hold until consumed).
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        per-requester handshake (ready one-hot or 0)
//   req_aluc/req_a/req_b       packed per-requester opcode and operands
//   alu_a/alu_b/alu_aluc       registered drive into the ALU
//   alu_out/alu_carry          ALU result back
//   rsp_valid/rsp_ready        response handshake
//   rsp_id/rsp_out/rsp_carry   tagged response payload
//   rsp_err                    illegal-opcode flag
//
// Build option: ALU_ILLEGAL_CHK_EN -- when defined, opcode 4'b1011 is caught
// at accept, never reaches the ALU, and answers next cycle with rsp_err=1
// and a zero result. When undefined, rsp_err is tied low and 4'b1011 is
// issued like any other opcode.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_WDTH = DATA_WDTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*4-1:0]           req_aluc,
  input  logic [NUM_REQ*DATA_WDTH-1:0]   req_a,
  input  logic [NUM_REQ*DATA_WDTH-1:0]   req_b,
  output logic [DATA_WDTH-1:0]           alu_a,
  output logic [DATA_WDTH-1:0]           alu_b,
  output logic [3:0]                     alu_aluc,
  input  logic [DATA_WDTH-1:0]           alu_out,
  input  logic                           alu_carry,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
  output logic [DATA_WDTH-1:0]           rsp_out,
  output logic                           rsp_carry,
  output logic                           rsp_err
);

  localparam int IW = $clog2(NUM_REQ);

  state_e                 state, state_nxt;
  logic [IW-1:0]          ptr;
  logic [IW-1:0]          gidx;
  logic [NUM_REQ-1:0]     grant;
  logic                   any;
  logic                   accept;
  logic                   illegal;
  logic [3:0]             sel_aluc;
  logic [DATA_WDTH-1:0]   sel_a, sel_b;

  rr_arb #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (any)
  );

  always_comb begin
    sel_aluc = req_aluc[4*int'(gidx) +: 4];
    sel_a    = req_a[DATA_WDTH*int'(gidx) +: DATA_WDTH];
    sel_b    = req_b[DATA_WDTH*int'(gidx) +: DATA_WDTH];
  end

`ifdef ALU_ILLEGAL_CHK_EN
  assign illegal = (sel_aluc == ALUC_ILLEGAL);
`else
  assign illegal = 1'b0;
`endif

  assign accept    = (state == IDLE) && any;
  assign req_ready = (state == IDLE) ? grant : '0;
  assign rsp_valid = (state == RESP);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any) state_nxt = illegal ? RESP : EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) ptr <= (gidx == IW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
    end
  end

  // ALU drive only moves on a real (legal) accept; the ALU sees stable
  // operands for the whole EXEC cycle and afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_aluc <= '0;
    end else if (accept && !illegal) begin
      alu_a    <= sel_a;
      alu_b    <= sel_b;
      alu_aluc <= sel_aluc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id    <= '0;
      rsp_out   <= '0;
      rsp_carry <= 1'b0;
    end else begin
      if (accept) rsp_id <= gidx;
      if (accept && illegal) begin
        rsp_out   <= '0;
        rsp_carry <= 1'b0;
      end else if (state == EXEC) begin
        rsp_out   <= alu_out;
        rsp_carry <= alu_carry;
      end
    end
  end

`ifdef ALU_ILLEGAL_CHK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (accept) err_q <= illegal;
  end
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule
